// File: rtl/cpt_pkg.sv
// Shared types and elaboration-time helpers for the cpt_* modulo counter family.
package cpt_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cpt_dir_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Ceiling log2 keeps the modulo check free of 2**size overflow for wide counters.
  function automatic bit modulo_ok(input int size, input int modulo);
    return (size >= 1) && (modulo >= 2) && (clog2(modulo) <= size);
  endfunction

  function automatic bit reset_ok(input int rst_value, input int modulo);
    return (rst_value >= 0) && (rst_value < modulo);
  endfunction

endpackage

// File: rtl/cpt_next_val.sv
// Combinational next-count and limit detect for one modulo counter stage.
// With CPT_SATURATE_EN defined the stage holds at the range limits instead of wrapping.
module cpt_next_val
  import cpt_pkg::*;
#(
  parameter int OUTPUT_SIZE  = 4,
  parameter int MODULO_VALUE = 10
) (
  input  logic [OUTPUT_SIZE-1:0] q,
  input  cpt_dir_t               dir,
  output logic [OUTPUT_SIZE-1:0] next_q,
  output logic                   wrap
);

  localparam int                     W1      = OUTPUT_SIZE + 1;
  localparam logic [W1-1:0]          MOD_EXT = W1'(MODULO_VALUE);
  localparam logic [OUTPUT_SIZE-1:0] MAX_VAL = OUTPUT_SIZE'(MODULO_VALUE - 1);
  localparam logic [OUTPUT_SIZE-1:0] ZERO    = {OUTPUT_SIZE{1'b0}};
  localparam logic [OUTPUT_SIZE-1:0] ONE     = OUTPUT_SIZE'(1);

  logic [W1-1:0]          inc_s;
  logic [OUTPUT_SIZE-1:0] dec_s;
  logic                   at_top_s;
  logic                   at_bottom_s;

  // One extra bit so a full binary range (modulo = 2**size) compares correctly.
  assign inc_s       = {1'b0, q} + W1'(1);
  assign dec_s       = q - ONE;
  assign at_top_s    = (inc_s == MOD_EXT);
  assign at_bottom_s = (q == ZERO);

  // Select next value and limit event from the counting direction.
  always_comb begin
    next_q = q;
    wrap   = 1'b0;
    case (dir)
      DIR_UP: begin
`ifdef CPT_SATURATE_EN
        next_q = at_top_s ? q : inc_s[OUTPUT_SIZE-1:0];
`else
        next_q = at_top_s ? ZERO : inc_s[OUTPUT_SIZE-1:0];
`endif
        wrap   = at_top_s;
      end
      DIR_DOWN: begin
`ifdef CPT_SATURATE_EN
        next_q = at_bottom_s ? q : dec_s;
`else
        next_q = at_bottom_s ? MAX_VAL : dec_s;
`endif
        wrap   = at_bottom_s;
      end
      default: begin
        next_q = q;
        wrap   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpt_nbits_updown.sv
// Up/down modulo-N counter with set, load, terminal count and wrap/overflow flags.
// Define CPT_SATURATE_EN to hold at the limits instead of wrapping (Wrap then never pulses).
module cpt_nbits_updown
  import cpt_pkg::*;
#(
  parameter int OUTPUT_SIZE  = 4,
  parameter int MODULO_VALUE = 10,
  parameter int RESET_VALUE  = 0
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   nSet,
  input  logic                   Load,
  input  logic [OUTPUT_SIZE-1:0] LoadVal,
  input  logic                   En,
  input  logic                   Up,
  input  logic                   ClrOvf,
  output logic [OUTPUT_SIZE-1:0] Q,
  output logic                   Tc,
  output logic                   Wrap,
  output logic                   Ovf,
  output logic                   LoadErr
);

  localparam int                     W1      = OUTPUT_SIZE + 1;
  localparam logic [W1-1:0]          MOD_EXT = W1'(MODULO_VALUE);
  localparam logic [OUTPUT_SIZE-1:0] MAX_VAL = OUTPUT_SIZE'(MODULO_VALUE - 1);
  localparam logic [OUTPUT_SIZE-1:0] RST_VAL = OUTPUT_SIZE'(RESET_VALUE);
`ifdef CPT_SATURATE_EN
  localparam logic WRAP_PULSE = 1'b0;
`else
  localparam logic WRAP_PULSE = 1'b1;
`endif

  if (!modulo_ok(OUTPUT_SIZE, MODULO_VALUE)) begin : g_bad_modulo
    $error("cpt_nbits_updown: MODULO_VALUE out of range for OUTPUT_SIZE");
  end
  if (!reset_ok(RESET_VALUE, MODULO_VALUE)) begin : g_bad_reset
    $error("cpt_nbits_updown: RESET_VALUE must be below MODULO_VALUE");
  end

  logic [OUTPUT_SIZE-1:0] q_r;
  logic [OUTPUT_SIZE-1:0] q_nxt_s;
  logic [OUTPUT_SIZE-1:0] cnt_next_s;
  logic                   cnt_wrap_s;
  logic                   wrap_r;
  logic                   wrap_nxt_s;
  logic                   ovf_r;
  logic                   ovf_nxt_s;
  logic                   ovf_kept_s;
  logic                   load_err_r;
  logic                   load_err_nxt_s;
  logic                   load_ok_s;
  cpt_dir_t               dir_s;

  assign dir_s      = Up ? DIR_UP : DIR_DOWN;
  assign load_ok_s  = ({1'b0, LoadVal} < MOD_EXT);
  assign ovf_kept_s = ovf_r & ~ClrOvf;

  cpt_next_val #(
    .OUTPUT_SIZE (OUTPUT_SIZE),
    .MODULO_VALUE(MODULO_VALUE)
  ) u_next_val (
    .q     (q_r),
    .dir   (dir_s),
    .next_q(cnt_next_s),
    .wrap  (cnt_wrap_s)
  );

  // Terminal count depends only on En, Up and Q so stages can cascade in one cycle.
  assign Tc      = En & cnt_wrap_s;
  assign Q       = q_r;
  assign Wrap    = wrap_r;
  assign Ovf     = ovf_r;
  assign LoadErr = load_err_r;

  // Priority mux: set over load over count; a wrap on the same edge beats ClrOvf.
  always_comb begin
    q_nxt_s        = q_r;
    wrap_nxt_s     = 1'b0;
    ovf_nxt_s      = ovf_kept_s;
    load_err_nxt_s = 1'b0;
    if (!nSet) begin
      q_nxt_s = MAX_VAL;
    end else if (Load) begin
      q_nxt_s        = load_ok_s ? LoadVal : MAX_VAL;
      load_err_nxt_s = ~load_ok_s;
    end else if (En) begin
      q_nxt_s    = cnt_next_s;
      wrap_nxt_s = cnt_wrap_s & WRAP_PULSE;
      ovf_nxt_s  = ovf_kept_s | cnt_wrap_s;
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State and flag registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      q_r        <= RST_VAL;
      wrap_r     <= 1'b0;
      ovf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_nxt_s;
      wrap_r     <= wrap_nxt_s;
      ovf_r      <= ovf_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_cpt_nbits_updown.sv
// Directed bench for cpt_nbits_updown (OUTPUT_SIZE=4, MODULO_VALUE=10) plus a two-digit cascade.
module tb_cpt_nbits_updown;

  logic       clk;
  logic       n_reset, n_set, load, en, up, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, ovf, load_err;

  logic       c_n_reset, c_en;
  logic [3:0] units_q, tens_q;
  logic       units_tc, units_wrap, units_ovf, units_err;
  logic       tens_tc, tens_wrap, tens_ovf, tens_err;

  int checks = 0;
  int errors = 0;

  cpt_nbits_updown #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .RESET_VALUE(0)) dut (
    .Clk(clk), .nReset(n_reset), .nSet(n_set), .Load(load), .LoadVal(load_val),
    .En(en), .Up(up), .ClrOvf(clr_ovf),
    .Q(q), .Tc(tc), .Wrap(wrap), .Ovf(ovf), .LoadErr(load_err)
  );

  cpt_nbits_updown #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .RESET_VALUE(0)) units (
    .Clk(clk), .nReset(c_n_reset), .nSet(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .En(c_en), .Up(1'b1), .ClrOvf(1'b0),
    .Q(units_q), .Tc(units_tc), .Wrap(units_wrap), .Ovf(units_ovf), .LoadErr(units_err)
  );

  cpt_nbits_updown #(.OUTPUT_SIZE(4), .MODULO_VALUE(10), .RESET_VALUE(0)) tens (
    .Clk(clk), .nReset(c_n_reset), .nSet(1'b1), .Load(1'b0), .LoadVal(4'd0),
    .En(units_tc), .Up(1'b1), .ClrOvf(1'b0),
    .Q(tens_q), .Tc(tens_tc), .Wrap(tens_wrap), .Ovf(tens_ovf), .LoadErr(tens_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    n_reset = 1'b0; n_set = 1'b1; load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; n_set = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({q, wrap, ovf, load_err} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got q=%0d wrap=%b ovf=%b err=%b expected q=0 wrap=0 ovf=0 err=0",
               q, wrap, ovf, load_err);
    end
    do_reset();
  endtask

  task automatic test_load();
    logic       t_nset [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] t_val  [7] = '{4'd7, 4'd12, 4'd3, 4'd5, 4'd0, 4'd10, 4'd9};
    logic [3:0] t_q    [7] = '{4'd7, 4'd9, 4'd3, 4'd9, 4'd0, 4'd9, 4'd9};
    logic       t_err  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_set = t_nset[i]; load = 1'b1; load_val = t_val[i];
      @(negedge clk);
      #1;
      checks++;
      if ({q, load_err} !== {t_q[i], t_err[i]}) begin
        errors++;
        $display("FAIL load[%0d]: got q=%0d err=%b expected q=%0d err=%b",
                 i, q, load_err, t_q[i], t_err[i]);
      end
    end
    n_set = 1'b1; load = 1'b0; en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({q, load_err} !== {4'd9, 1'b0}) begin
      errors++;
      $display("FAIL load_hold: got q=%0d err=%b expected q=9 err=0", q, load_err);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    load = 1'b1; load_val = 4'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1;
    @(negedge clk);
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    @(negedge clk);
    #1;
    checks++;
    if ({q, ovf} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL prio_setup: got q=%0d ovf=%b expected q=5 ovf=1", q, ovf);
    end
    n_reset = 1'b0; load = 1'b1; load_val = 4'd12; en = 1'b1;
    #2;
    checks++;
    if (q !== 4'd5) begin
      errors++;
      $display("FAIL reset_sync: got q=%0d expected q=5", q);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({q, wrap, ovf, load_err} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_prio: got q=%0d wrap=%b ovf=%b err=%b expected q=0 wrap=0 ovf=0 err=0",
               q, wrap, ovf, load_err);
    end
    n_reset = 1'b1; load = 1'b0; en = 1'b0;
  endtask

`ifdef CPT_SATURATE_EN
  task automatic test_saturate();
    logic [3:0] exp_q;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_q = (i < 9) ? 4'(i) : 4'd9;
      #1;
      checks++;
      if ({q, tc, wrap, ovf} !== {exp_q, exp_q == 4'd9, 1'b0, i >= 10}) begin
        errors++;
        $display("FAIL sat_up[%0d]: got q=%0d tc=%b wrap=%b ovf=%b expected q=%0d tc=%b wrap=0 ovf=%b",
                 i, q, tc, wrap, ovf, exp_q, exp_q == 4'd9, i >= 10);
      end
      @(negedge clk);
    end
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({q, tc, wrap, ovf} !== {4'd0, 1'b1, 1'b0, i >= 1}) begin
        errors++;
        $display("FAIL sat_down[%0d]: got q=%0d tc=%b wrap=%b ovf=%b expected q=0 tc=1 wrap=0 ovf=%b",
                 i, q, tc, wrap, ovf, i >= 1);
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask
`else
  task automatic test_count_up();
    logic [3:0] exp_q;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q = 4'(i % 10);
      #1;
      checks++;
      if ({q, tc, wrap, ovf} !== {exp_q, exp_q == 4'd9, i == 10, i >= 10}) begin
        errors++;
        $display("FAIL count_up[%0d]: got q=%0d tc=%b wrap=%b ovf=%b expected q=%0d tc=%b wrap=%b ovf=%b",
                 i, q, tc, wrap, ovf, exp_q, exp_q == 4'd9, i == 10, i >= 10);
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q;
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q = 4'((10 - i) % 10);
      #1;
      checks++;
      if ({q, tc, wrap, ovf} !== {exp_q, i == 0, i == 1, i >= 1}) begin
        errors++;
        $display("FAIL count_down[%0d]: got q=%0d tc=%b wrap=%b ovf=%b expected q=%0d tc=%b wrap=%b ovf=%b",
                 i, q, tc, wrap, ovf, exp_q, i == 0, i == 1, i >= 1);
      end
      @(negedge clk);
    end
    // Q is 6 here; reverse direction and climb to the top.
    up = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({q, tc} !== {4'd7, 1'b0}) begin
      errors++;
      $display("FAIL dir_change: got q=%0d tc=%b expected q=7 tc=0", q, tc);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({q, tc} !== {4'd9, 1'b1}) begin
      errors++;
      $display("FAIL up_tc: got q=%0d tc=%b expected q=9 tc=1", q, tc);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({q, wrap, ovf} !== {4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL clr_vs_wrap: got q=%0d wrap=%b ovf=%b expected q=0 wrap=1 ovf=1", q, wrap, ovf);
    end
    en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({q, wrap, ovf} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clr_ovf: got q=%0d wrap=%b ovf=%b expected q=0 wrap=0 ovf=0", q, wrap, ovf);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_cascade();
    logic [3:0] exp_t, exp_u;
    c_n_reset = 1'b0; c_en = 1'b0;
    @(negedge clk);
    c_n_reset = 1'b1; c_en = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      exp_t = 4'((i / 10) % 10);
      exp_u = 4'(i % 10);
      #1;
      checks++;
      if ({tens_q, units_q, tens_wrap} !== {exp_t, exp_u, i == 100}) begin
        errors++;
        $display("FAIL cascade[%0d]: got %0d%0d tens_wrap=%b expected %0d%0d tens_wrap=%b",
                 i, tens_q, units_q, tens_wrap, exp_t, exp_u, i == 100);
      end
      @(negedge clk);
    end
    c_en = 1'b0;
  endtask
`endif

  initial begin
    n_reset = 1'b0; n_set = 1'b1; load = 1'b0; load_val = 4'd0;
    en = 1'b0; up = 1'b1; clr_ovf = 1'b0;
    c_n_reset = 1'b0; c_en = 1'b0;
    test_reset();
`ifdef CPT_SATURATE_EN
    test_saturate();
`else
    test_count_up();
    test_count_down();
    test_cascade();
`endif
    test_load();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
